// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the main-memory block responder.
// The reset-time fill pattern produced by init_word is used when MEM_INIT_PATTERN_EN is defined.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam int unsigned MAX_BLOCK_SIZE = 1024;

    // Replicates the low byte of a block index across num_bytes byte lanes.
    function automatic logic [MAX_BLOCK_SIZE-1:0] init_word(input logic [7:0] blk,
                                                            input int unsigned num_bytes);
        logic [MAX_BLOCK_SIZE-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < MAX_BLOCK_SIZE / 8; i++) begin
            if (i < num_bytes) w[i*8 +: 8] = blk;
        end
        return w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned delay);
        return (delay < 1) ? 1 : $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/mem_delay_counter.sv
// Loadable down-counter that sets the wait time between request accept and response.
module mem_delay_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/mem_block_responder.sv
// Main-memory block responder: one block request at a time, answered after MEM_DELAY wait cycles.
// Define MEM_INIT_PATTERN_EN to have reset fill every block with its replicated index byte.
module mem_block_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_LENGTH = 10,
    parameter int unsigned BLOCK_SIZE  = 32,
    parameter int unsigned MEM_DELAY   = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   write,
    input  logic [ADDR_LENGTH-1:0] addr,
    input  logic [BLOCK_SIZE-1:0]  data_in,
    output logic [BLOCK_SIZE-1:0]  data_out,
    output logic                   fetchComplete,
    output logic                   busy
);

    localparam int unsigned BYTE_SELECT_SIZE = $clog2(BLOCK_SIZE / 8);
    localparam int unsigned IDX_W            = ADDR_LENGTH - BYTE_SELECT_SIZE;
    localparam int unsigned NUM_BLOCKS       = 2 ** IDX_W;
    localparam int unsigned CNT_W            = cnt_width(MEM_DELAY);

    mem_state_t            state;
    logic [IDX_W-1:0]      blk_q;
    logic                  wr_q;
    logic [BLOCK_SIZE-1:0] wdata_q;

    logic load_c;
    logic dec_c;
    logic fire_c;
    logic zero_c;

`ifdef MEM_INIT_PATTERN_EN
    logic [BLOCK_SIZE-1:0] mem [NUM_BLOCKS];
`else
    logic [BLOCK_SIZE-1:0] mem [NUM_BLOCKS] = '{default: '0};
`endif

    // Byte-select bits only pick a byte inside the block; they never reach the array.
    generate
        if (BYTE_SELECT_SIZE > 0) begin : g_bsel
            logic unused_bsel_c;
            assign unused_bsel_c = ^addr[BYTE_SELECT_SIZE-1:0];
        end
    endgenerate

    assign load_c = (state == IDLE) && enable;
    assign dec_c  = (state == WAIT) && !zero_c;
    assign fire_c = (state == WAIT) && zero_c;

    mem_delay_counter #(
        .CNT_W(CNT_W)
    ) u_delay (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_c),
        .dec        (dec_c),
        .load_value (CNT_W'(MEM_DELAY)),
        .zero_c     (zero_c)
    );

    // Request FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            data_out      <= '0;
            fetchComplete <= 1'b0;
            busy          <= 1'b0;
            blk_q         <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        blk_q   <= addr[ADDR_LENGTH-1:BYTE_SELECT_SIZE];
                        wr_q    <= write;
                        wdata_q <= data_in;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (zero_c) begin
                        fetchComplete <= 1'b1;
                        data_out      <= wr_q ? wdata_q : mem[blk_q];
                        state         <= RESP;
                    end
                end
                RESP: begin
                    fetchComplete <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    fetchComplete <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Backing array; a reset mid-request drops the pending write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
`ifdef MEM_INIT_PATTERN_EN
            for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
                mem[b] <= BLOCK_SIZE'(init_word(8'(b), BLOCK_SIZE / 8));
            end
`endif
        end else if (fire_c && wr_q) begin
            mem[blk_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: a MEM_DELAY=20 instance and a MEM_DELAY=0 instance.
// Expected read data follows the MEM_INIT_PATTERN_EN build setting.
module tb_mem_block_responder;

`ifdef MEM_INIT_PATTERN_EN
    localparam logic [31:0] EXP_BLK2   = 32'h02020202;
    localparam logic [31:0] EXP_BLK4   = 32'h04040404;
    localparam logic [31:0] EXP_BLK255 = 32'hFFFFFFFF;
`else
    localparam logic [31:0] EXP_BLK2   = 32'h00000000;
    localparam logic [31:0] EXP_BLK4   = 32'h00000000;
    localparam logic [31:0] EXP_BLK255 = 32'h00000000;
`endif

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        write;
    logic [9:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        fetch_complete;
    logic        busy;

    logic        enable0;
    logic        write0;
    logic [9:0]  addr0;
    logic [31:0] data_in0;
    logic [31:0] data_out0;
    logic        fetch_complete0;
    logic        busy0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_block_responder #(.ADDR_LENGTH(10), .BLOCK_SIZE(32), .MEM_DELAY(20)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .write         (write),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .fetchComplete (fetch_complete),
        .busy          (busy)
    );

    mem_block_responder #(.ADDR_LENGTH(10), .BLOCK_SIZE(32), .MEM_DELAY(0)) dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable0),
        .write         (write0),
        .addr          (addr0),
        .data_in       (data_in0),
        .data_out      (data_out0),
        .fetchComplete (fetch_complete0),
        .busy          (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one request to the MEM_DELAY=20 instance; returns cycles from accept to pulse (-1 on timeout).
    task automatic req(input logic w, input logic [9:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rdata);
        enable  = 1'b1;
        write   = w;
        addr    = a;
        data_in = d;
        tick();
        enable  = 1'b0;
        write   = ~w;
        addr    = ~a;
        data_in = ~d;
        lat     = -1;
        rdata   = 'x;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (fetch_complete === 1'b1) begin
                lat   = i;
                rdata = data_out;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          pulses;
        int          pulse_at;
        logic [31:0] rdata;

        reset_n  = 1'b0;
        enable   = 1'b1;
        write    = 1'b0;
        addr     = 10'h008;
        data_in  = 32'h0;
        enable0  = 1'b1;
        write0   = 1'b0;
        addr0    = 10'h000;
        data_in0 = 32'h0;

        // Reset held with enable asserted: everything stays quiet.
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_data_out", 64'(data_out), 64'h0);
            chk("rst_fc", 64'(fetch_complete), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
            tick();
        end
        enable  = 1'b0;
        enable0 = 1'b0;
        reset_n = 1'b1;
        tick();

        // Read latency and width of the ack pulse.
        req(1'b0, 10'h008, 32'h0, lat, rdata);
        chk("rd8_latency", 64'(lat), 64'd21);
        chk("rd8_data", 64'(rdata), 64'(EXP_BLK2));
        tick();
        chk("rd8_pulse_width", 64'(fetch_complete), 64'h0);
        chk("rd8_busy_after", 64'(busy), 64'h0);

        // Write then read an aliasing address in the same block.
        req(1'b1, 10'h004, 32'hDEADBEEF, lat, rdata);
        chk("wr4_latency", 64'(lat), 64'd21);
        chk("wr4_echo", 64'(rdata), 64'hDEADBEEF);
        tick();
        req(1'b0, 10'h007, 32'h0, lat, rdata);
        chk("rd7_latency", 64'(lat), 64'd21);
        chk("rd7_data", 64'(rdata), 64'hDEADBEEF);
        tick();

        // Request during WAIT is dropped.
        enable = 1'b1;
        write  = 1'b0;
        addr   = 10'h010;
        tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        addr   = 10'h100;
        tick();
        enable   = 1'b0;
        pulses   = 0;
        pulse_at = -1;
        rdata    = 32'h0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (fetch_complete === 1'b1) begin
                pulses++;
                if (pulse_at < 0) begin
                    pulse_at = i;
                    rdata    = data_out;
                end
            end
        end
        chk("drop_pulse_count", 64'(pulses), 64'd1);
        chk("drop_pulse_time", 64'(pulse_at), 64'd19);
        chk("drop_data", 64'(rdata), 64'(EXP_BLK4));

        // Reset in the middle of a write aborts it.
        enable  = 1'b1;
        write   = 1'b1;
        addr    = 10'h3FC;
        data_in = 32'h12345678;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_busy_before", 64'(busy), 64'h1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_busy_after", 64'(busy), 64'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fetch_complete === 1'b1) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        req(1'b0, 10'h3FC, 32'h0, lat, rdata);
        chk("abort_read_data", 64'(rdata), 64'(EXP_BLK255));
        tick();

        // Zero-delay instance at the top address.
        enable0 = 1'b1;
        write0  = 1'b0;
        addr0   = 10'h3FF;
        tick();
        enable0 = 1'b0;
        addr0   = 10'h000;
        chk("d0_busy_c1", 64'(busy0), 64'h1);
        chk("d0_fc_c1", 64'(fetch_complete0), 64'h0);
        tick();
        chk("d0_busy_c2", 64'(busy0), 64'h1);
        chk("d0_fc_c2", 64'(fetch_complete0), 64'h1);
        chk("d0_data", 64'(data_out0), 64'(EXP_BLK255));
        tick();
        chk("d0_busy_c3", 64'(busy0), 64'h0);
        chk("d0_fc_c3", 64'(fetch_complete0), 64'h0);
        chk("d0_data_held", 64'(data_out0), 64'(EXP_BLK255));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
